// File: rtl/lm70_spi_reader_if.sv
// Sensor-side and result-side signals of the LM70 reader, bundled for the top-level port.
// master = the reader itself, slave = whatever drives ena/sio and consumes the results.
interface lm70_spi_reader_if;
  logic       ena;
  logic       sio;
  logic       cs_n;
  logic       sck;
  logic [7:0] temp_c;
  logic       temp_neg;
  logic       temp_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  ena, sio,
    output cs_n, sck, temp_c, temp_neg, temp_valid, frame_err, busy
  );

  modport slave (
    output ena, sio,
    input  cs_n, sck, temp_c, temp_neg, temp_valid, frame_err, busy
  );
endinterface

// File: rtl/lm70_spi_reader.sv
// LM70 temperature reader: polls the sensor over 3-wire SPI and publishes whole-degree results.
// Define LM70_AVG4_EN to publish a running 4-sample average in place of the raw sample.
//
// state | meaning
// IDLE  | cs_n high, sck low, waiting for ena
// SETUP | cs_n low, sck low for one half period before the first edge
// SHIFT | 16 sck pulses, sio captured on each rising edge
// HOLD  | cs_n low, sck low for one half period after the last edge
// GAP   | cs_n high between frames; result published in its first cycle
module lm70_spi_reader #(
  parameter int unsigned SCK_HALF   = 2,  // 1..15
  parameter int unsigned GAP_CYCLES = 8   // 1..255
) (
  input  logic               clk,
  input  logic               rst_n,
  lm70_spi_reader_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam logic [7:0] SCK_LOAD = 8'(SCK_HALF - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t       state_q, state_nx;
  logic [7:0]   cnt_q, cnt_nx;
  logic [4:0]   half_q, half_nx;
  logic         sck_q, sck_nx;
  logic         cs_n_q, cs_n_nx;
  logic [15:0]  sr_q, sr_nx;
  logic         eval;

  logic [7:0]   temp_c_q;
  logic         temp_neg_q;
  logic         temp_valid_q;
  logic         frame_err_q;

  logic         frame_ok;
  logic signed [8:0] sample;
  logic signed [8:0] pub;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      sr_q    <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      half_q  <= half_nx;
      sck_q   <= sck_nx;
      cs_n_q  <= cs_n_nx;
      sr_q    <= sr_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    half_nx  = half_q;
    sr_nx    = sr_q;
    eval     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.ena) begin
          state_nx = ST_SETUP;
          cnt_nx   = SCK_LOAD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_nx = ST_SHIFT;
          cnt_nx   = SCK_LOAD;
          half_nx  = 5'd0;
        end else begin
          cnt_nx = cnt_q - 8'd1;
        end
      end
      ST_SHIFT: begin
        // half_q counts sck half periods; its LSB is the sck level
        if (cnt_q == 8'd0) begin
          cnt_nx = SCK_LOAD;
          if (half_q == 5'd31) begin
            state_nx = ST_HOLD;
            half_nx  = 5'd0;
          end else begin
            half_nx = half_q + 5'd1;
          end
        end else begin
          cnt_nx = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_nx = ST_GAP;
          cnt_nx   = GAP_LOAD;
          eval     = 1'b1;
        end else begin
          cnt_nx = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          if (bus.ena) begin
            state_nx = ST_SETUP;
            cnt_nx   = SCK_LOAD;
          end else begin
            state_nx = ST_IDLE;
            cnt_nx   = 8'd0;
          end
        end else begin
          cnt_nx = cnt_q - 8'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 8'd0;
        half_nx  = 5'd0;
      end
    endcase

    cs_n_nx = !((state_nx == ST_SETUP) || (state_nx == ST_SHIFT) || (state_nx == ST_HOLD));
    sck_nx  = (state_nx == ST_SHIFT) && half_nx[0];

    if (sck_nx && !sck_q)
      sr_nx = {sr_q[14:0], bus.sio};
  end

  assign frame_ok = (sr_q[4:2] == 3'b111);
  assign sample   = $signed(sr_q[15:7]);

`ifdef LM70_AVG4_EN
  logic signed [8:0]  hist0_q, hist1_q, hist2_q;
  logic               primed_q;
  logic signed [10:0] sum;

  // sum of the new sample and the three previous accepted samples
  assign sum = {{2{sample[8]}},  sample}  + {{2{hist0_q[8]}}, hist0_q} +
               {{2{hist1_q[8]}}, hist1_q} + {{2{hist2_q[8]}}, hist2_q};

  always_comb begin
    pub = sample;
    if (primed_q)
      pub = sum[10:2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist0_q  <= '0;
      hist1_q  <= '0;
      hist2_q  <= '0;
      primed_q <= 1'b0;
    end else if (eval && frame_ok) begin
      primed_q <= 1'b1;
      if (!primed_q) begin
        hist0_q <= sample;
        hist1_q <= sample;
        hist2_q <= sample;
      end else begin
        hist0_q <= sample;
        hist1_q <= hist0_q;
        hist2_q <= hist1_q;
      end
    end
  end
`else
  assign pub = sample;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      temp_c_q     <= '0;
      temp_neg_q   <= 1'b0;
      temp_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      temp_valid_q <= eval && frame_ok;
      frame_err_q  <= eval && !frame_ok;
      if (eval && frame_ok) begin
        temp_neg_q <= pub[8];
        temp_c_q   <= pub[8] ? 8'd0 : pub[7:0];
      end
    end
  end

  assign bus.cs_n       = cs_n_q;
  assign bus.sck        = sck_q;
  assign bus.temp_c     = temp_c_q;
  assign bus.temp_neg   = temp_neg_q;
  assign bus.temp_valid = temp_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lm70_spi_reader.sv
// Bench for lm70_spi_reader: emulates the LM70 on sio and compares every published result
// against a frame-level reference model (raw or 4-sample average when LM70_AVG4_EN is defined).
module tb_lm70_spi_reader;

  localparam int SH  = 2;
  localparam int GAP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lm70_spi_reader_if ifc ();

  lm70_spi_reader #(.SCK_HALF(SH), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // LM70 emulation and bus monitor, all sampled on the falling clk edge
  logic [15:0] tx_frame = 16'h0000;
  logic [15:0] sio_frame = 16'h0000;
  int  sio_idx = 16;
  bit  mon_prev_cs = 1'b1;
  bit  mon_prev_sck = 1'b0;
  int  low_cnt = 0;
  int  rise_cnt = 0;
  int  fall_cnt = 0;
  int  valid_cnt = 0;

  always @(negedge clk) begin
    if (ifc.cs_n === 1'b0 && mon_prev_cs) begin
      low_cnt   <= 1;
      rise_cnt  <= 0;
      fall_cnt  <= fall_cnt + 1;
      sio_frame <= tx_frame;
      sio_idx   <= 1;
      ifc.sio   <= tx_frame[15];
    end else begin
      if (ifc.cs_n === 1'b0) low_cnt <= low_cnt + 1;
      if (ifc.sck === 1'b0 && mon_prev_sck && ifc.cs_n === 1'b0) begin
        ifc.sio <= (sio_idx < 16) ? sio_frame[15 - sio_idx] : 1'b0;
        sio_idx <= sio_idx + 1;
      end
      if (ifc.sck === 1'b1 && !mon_prev_sck) rise_cnt <= rise_cnt + 1;
    end
    if (ifc.temp_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    mon_prev_cs  <= (ifc.cs_n !== 1'b0);
    mon_prev_sck <= (ifc.sck === 1'b1);
  end

  // reference model: frame -> accepted temperature, optional 4-deep floor average
  int         hist[$];
  logic [7:0] m_c = 8'd0;
  bit         m_neg = 1'b0;

  task automatic model_reset();
    hist.delete();
    m_c   = 8'd0;
    m_neg = 1'b0;
  endtask

  function automatic int floor_div4(input int s);
    if (s >= 0) return s / 4;
    return -((-s + 3) / 4);
  endfunction

  task automatic model_frame(input logic [15:0] f, output bit ok);
    int v;
    int s;
    ok = (f[4:2] == 3'b111);
    if (ok) begin
      v = int'(f[15:7]);
      if (v >= 256) v = v - 512;
`ifdef LM70_AVG4_EN
      if (hist.size() == 0) begin
        for (int i = 0; i < 4; i++) hist.push_back(v);
      end else begin
        hist.push_back(v);
        void'(hist.pop_front());
      end
      s = 0;
      foreach (hist[i]) s += hist[i];
      v = floor_div4(s);
`else
      s = v;
`endif
      m_neg = (v < 0);
      m_c   = (v < 0) ? 8'd0 : 8'(v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    ifc.ena = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", ifc.cs_n, 1);
    check("rst_sck", ifc.sck, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_temp_c", ifc.temp_c, 0);
    check("rst_temp_neg", ifc.temp_neg, 0);
    check("rst_pulses", {ifc.temp_valid, ifc.frame_err}, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_pulse(output bit seen);
    int n = 0;
    seen = 1'b0;
    while (n < 600) begin
      @(negedge clk);
      n++;
      if (ifc.temp_valid === 1'b1 || ifc.frame_err === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("pulse_timeout", 0, 1);
  endtask

  task automatic run_frame(input logic [15:0] f);
    bit seen;
    bit ok;
    tx_frame = f;
    ifc.ena  = 1'b1;
    wait_pulse(seen);
    if (seen) begin
      model_frame(f, ok);
      check("temp_valid", ifc.temp_valid, ok);
      check("frame_err", ifc.frame_err, !ok);
      check("temp_c", ifc.temp_c, m_c);
      check("temp_neg", ifc.temp_neg, m_neg);
      check("cs_low_cycles", low_cnt, 34 * SH);
      check("sck_rises", rise_cnt, 16);
      check("busy_gap", ifc.busy, 1);
      @(negedge clk);
      check("pulse_width", {ifc.temp_valid, ifc.frame_err}, 0);
    end
  endtask

  task automatic wait_bit(input int nbits);
    int n = 0;
    while (!(ifc.cs_n === 1'b0 && rise_cnt == nbits) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) check("bit_timeout", 0, 1);
  endtask

  initial begin
    logic [15:0] f;
    bit seen;
    bit ok;
    int g;
    int v0;
    int f0;

    ifc.ena = 1'b0;

    // basic frames
    do_reset();
    run_frame(16'h0C9F);
    check("dir_25_c", ifc.temp_c, 25);
    check("dir_25_neg", ifc.temp_neg, 0);
    run_frame(16'h0C80);
    check("dir_err_hold", ifc.temp_c, 25);

    do_reset();
    run_frame(16'hF39F);
    check("dir_m25_c", ifc.temp_c, 0);
    check("dir_m25_neg", ifc.temp_neg, 1);

    // averaging directed pair (raw 20/40 without averaging)
    do_reset();
    run_frame(16'h0A1F);
    check("avg_first", ifc.temp_c, 20);
    run_frame(16'h141F);
`ifdef LM70_AVG4_EN
    check("avg_second", ifc.temp_c, 25);
`else
    check("avg_second", ifc.temp_c, 40);
`endif

    // randomized back-to-back frames, mostly valid
    do_reset();
    for (int i = 0; i < 24; i++) begin
      f = 16'($urandom);
      if ($urandom_range(0, 3) != 0) f[4:2] = 3'b111;
      run_frame(f);
    end

    // ena dropped during bit 5: frame and gap complete, then idle
    do_reset();
    tx_frame = 16'h0C9F;
    ifc.ena  = 1'b1;
    wait_bit(5);
    ifc.ena = 1'b0;
    wait_pulse(seen);
    if (seen) begin
      model_frame(16'h0C9F, ok);
      check("drop_valid", ifc.temp_valid, ok);
      check("drop_temp_c", ifc.temp_c, m_c);
      check("drop_cs_low", low_cnt, 34 * SH);
    end
    g = 0;
    while (ifc.busy === 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("drop_gap_len", g, GAP);
    f0 = fall_cnt;
    repeat (80) @(negedge clk);
    check("drop_no_restart", fall_cnt, f0);
    check("drop_idle_cs", ifc.cs_n, 1);
    check("drop_idle_busy", ifc.busy, 0);

    // reset asserted during SHIFT
    do_reset();
    run_frame(16'h0C9F);
    tx_frame = 16'h141F;
    wait_bit(3);
    v0 = valid_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_cs_n", ifc.cs_n, 1);
    check("mid_rst_sck", ifc.sck, 0);
    check("mid_rst_busy", ifc.busy, 0);
    check("mid_rst_temp_c", ifc.temp_c, 0);
    check("mid_rst_valid", ifc.temp_valid, 0);
    repeat (4) @(negedge clk);
    rst_n   = 1'b1;
    ifc.ena = 1'b0;
    model_reset();
    repeat (60) @(negedge clk);
    check("mid_rst_no_pulse", valid_cnt, v0);
    check("mid_rst_idle", ifc.busy, 0);

    // a frame after the mid-frame reset starts clean
    run_frame(16'h141F);
    ifc.ena = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lm70_spi_reader.md
LM70_SPI_READER -- requirements
Module: lm70_spi_reader

Interface
REQ-001 SHALL have parameter SCK_HALF, default 2: clk cycles per SCK half-period, legal range 1..15.
REQ-002 SHALL have parameter GAP_CYCLES, default 8: clk cycles with cs_n high between frames, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port ena, input, 1 bit: 1 runs back-to-back conversions, 0 stops after the current frame.
REQ-006 SHALL have port sio, input, 1 bit: LM70 serial data (MISO).
REQ-007 SHALL have port cs_n, output, 1 bit: LM70 chip select, active low.
REQ-008 SHALL have port sck, output, 1 bit: LM70 serial clock, idle low.
REQ-009 SHALL have port temp_c, output, 8 bits: unsigned whole-degree Celsius magnitude, clamped at 0 when negative.
REQ-010 SHALL have port temp_neg, output, 1 bit: 1 if the last accepted temperature was below 0 C.
REQ-011 SHALL have port temp_valid, output, 1 bit: one-cycle pulse when temp_c and temp_neg update.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame fails the check in REQ-021.
REQ-013 SHALL have port busy, output, 1 bit: 1 in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-015 IDLE: cs_n=1, sck=0; go to SETUP the cycle after ena=1 is sampled.
REQ-016 SETUP: cs_n=0, sck=0 for SCK_HALF cycles, then go to SHIFT.
REQ-017 SHIFT: sck SHALL toggle every SCK_HALF cycles, starting low, for exactly 16 rising and 16 falling edges; then go to HOLD with sck=0.
REQ-018 SHALL register sio into a 16-bit shift register, MSB first, in the same clk cycle that sck is driven 0->1.
REQ-019 HOLD: cs_n=0, sck=0 for SCK_HALF cycles; then cs_n=1, evaluate the frame, and go to GAP.
REQ-020 Temperature SHALL be frame[15:7] as 9-bit two's complement at 1 C/LSB; frame[6:0] is discarded after the check.
REQ-021 A frame is valid only if frame[4:2]==3'b111; otherwise pulse frame_err and leave temp_c/temp_neg unchanged.
REQ-022 On a valid frame with value >=0: temp_c=value[7:0], temp_neg=0; with value <0: temp_c=0, temp_neg=1.
REQ-023 temp_valid (or frame_err) SHALL pulse exactly one cycle, in the first GAP cycle, with outputs already updated.
REQ-024 GAP: cs_n=1 for GAP_CYCLES cycles; then go to SETUP if ena=1, else IDLE.
REQ-025 ena deasserted mid-frame SHALL NOT abort the frame; the frame completes, including its GAP.
REQ-026 cs_n low time per frame SHALL be exactly 2*SCK_HALF + 32*SCK_HALF cycles.

Reset
REQ-027 rst_n=0 sampled at a clk edge SHALL force IDLE, cs_n=1, sck=0, temp_c=0, temp_neg=0, temp_valid=0, frame_err=0, busy=0, shift register=0 and all counters=0.
REQ-028 Reset mid-frame SHALL drop cs_n high on that edge; no partial result is ever published.

Configuration
REQ-029 Macro LM70_AVG4_EN, when defined, SHALL compute a running 4-sample average over valid 9-bit signed samples (11-bit sum, arithmetic shift right by 2, truncating toward minus infinity) and publish the average in place of the raw sample.
REQ-030 With LM70_AVG4_EN defined, the first valid sample after reset SHALL prime all 4 entries; frame_err frames SHALL NOT enter the average; latency SHALL be unchanged.
REQ-031 Without LM70_AVG4_EN, each valid sample SHALL be published directly, and no averaging storage SHALL exist.

Verification
REQ-032 SCK_HALF=2, ena=1, sio frame 0x0C9F -> cs_n low 68 cycles, 16 sck pulses, temp_valid pulse, temp_c=25, temp_neg=0.
REQ-033 Frame 0xF39F (-25 C) -> temp_valid, temp_c=0, temp_neg=1.
REQ-034 Frame 0x0C9F, then frame 0x0C80 -> second frame pulses frame_err without temp_valid, and temp_c holds at 25.
REQ-035 ena dropped during bit 5 of a frame -> frame completes, GAP elapses, state returns to IDLE, and no further cs_n falling edge occurs.
REQ-036 rst_n low during SHIFT -> next edge cs_n=1, sck=0, busy=0, temp_c=0, with no temp_valid pulse.
REQ-037 LM70_AVG4_EN defined, frames 0x0A1F (20 C) then 0x141F (40 C) -> temp_c=20, then temp_c=25.
